// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and default sizing for the SPI master controller
package spi_pkg;

    localparam int SPI_CLK_DIV_DEF = 4;
    localparam int SPI_DATA_W_DEF  = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_XFER  = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } spi_state_e;

endpackage

// File: rtl/spi_master_ctrl_counter.sv
// rtl/spi_master_ctrl_counter.sv - modulo-M counter with enable and combinational carry-out
module spi_master_ctrl_counter #(
    parameter int M = 4,
    localparam int W = (M > 1) ? $clog2(M) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         co
);

    // carry is asserted in the enabled cycle that wraps M-1 back to 0
    assign co = en && (cnt == W'(M - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= co ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI mode-0 master: one DATA_W-bit full-duplex transfer per accepted start
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV_DEF,
    parameter int DATA_W  = SPI_DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    spi_state_e        state, state_nx;
    logic [DATA_W-1:0] tx_sr, tx_sr_nx, rx_sr;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic              div_en, div_co, bit_en, bit_co, cnt_clr;
    logic              sclk_rise, sclk_fall, active_nx;
    logic              cnt_unused;

    // the divider times SETUP and HOLD as well as the SCLK half-periods
    assign div_en    = (state == S_SETUP) || (state == S_XFER) || (state == S_HOLD);
    assign sclk_rise = (state == S_XFER) && div_co && !sclk;
    assign sclk_fall = (state == S_XFER) && div_co && sclk;
    assign bit_en    = sclk_fall;
    assign cnt_clr   = rst || (state == S_IDLE);
    assign cnt_unused = ^{div_cnt, bit_cnt};

    spi_master_ctrl_counter #(.M(CLK_DIV)) u_div (
        .clk (clk),
        .rst (cnt_clr),
        .en  (div_en),
        .cnt (div_cnt),
        .co  (div_co)
    );

    spi_master_ctrl_counter #(.M(DATA_W)) u_bit (
        .clk (clk),
        .rst (cnt_clr),
        .en  (bit_en),
        .cnt (bit_cnt),
        .co  (bit_co)
    );

    always_comb begin
        state_nx = state;
        tx_sr_nx = tx_sr;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_SETUP;
                    tx_sr_nx = tx_data;
                end
            end
            S_SETUP: begin
                if (div_co) state_nx = S_XFER;
            end
            S_XFER: begin
                if (sclk_fall) begin
                    tx_sr_nx = {tx_sr[DATA_W-2:0], 1'b0};
                    if (bit_co) state_nx = S_HOLD;
                end
            end
            S_HOLD: begin
                if (div_co) state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign active_nx = (state_nx == S_SETUP) || (state_nx == S_XFER) || (state_nx == S_HOLD);

    // pin outputs are registered from next-state values so they line up with the state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            tx_sr   <= '0;
            rx_sr   <= '0;
            rx_data <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            cs_n    <= 1'b1;
        end else begin
            state <= state_nx;
            tx_sr <= tx_sr_nx;
            if (sclk_rise) begin
                rx_sr <= {rx_sr[DATA_W-2:0], miso};
            end
            if (state_nx == S_DONE) begin
                rx_data <= rx_sr;
            end
            if (state_nx != S_XFER) begin
                sclk <= 1'b0;
            end else if (state == S_XFER && div_co) begin
                sclk <= ~sclk;
            end
            mosi <= active_nx & tx_sr_nx[DATA_W-1];
            cs_n <= ~active_nx;
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - directed self-checking bench for spi_master_ctrl
module tb_spi_master_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    int          total = 0;
    int          bad = 0;

    logic        start_a, loop_a, miso_a, miso_in_a;
    logic [7:0]  tx_a, rx_a;
    logic        busy_a, done_a, sclk_a, mosi_a, cs_n_a;

    logic        start_b, miso_in_b;
    logic [15:0] tx_b, rx_b;
    logic        busy_b, done_b, sclk_b, mosi_b, cs_n_b;

    assign miso_in_a = loop_a ? mosi_a : miso_a;
    assign miso_in_b = mosi_b;

    always #5 clk = ~clk;

    spi_master_ctrl dut_a (
        .clk(clk), .rst(rst), .start(start_a), .tx_data(tx_a),
        .busy(busy_a), .done(done_a), .rx_data(rx_a),
        .sclk(sclk_a), .mosi(mosi_a), .miso(miso_in_a), .cs_n(cs_n_a)
    );

    spi_master_ctrl #(.CLK_DIV(2), .DATA_W(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .tx_data(tx_b),
        .busy(busy_b), .done(done_b), .rx_data(rx_b),
        .sclk(sclk_b), .mosi(mosi_b), .miso(miso_in_b), .cs_n(cs_n_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transfer on dut_a; tx_data is inverted right after acceptance to show it is latched.
    task automatic xfer_a(input logic [7:0] tx, input bit pat_mode, input logic [7:0] pat,
                          output int done_cyc, output int busy_cnt, output int rises,
                          output logic [7:0] mosi_word, output logic mosi_or,
                          output logic cs1, output logic [7:0] rx_at_done);
        int   idx;
        logic prev_sclk;
        tx_a = tx; loop_a = !pat_mode; miso_a = pat[7]; idx = 0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; tx_a = ~tx;
        done_cyc = -1; busy_cnt = 0; rises = 0; mosi_word = '0; mosi_or = 1'b0;
        prev_sclk = 1'b0; cs1 = cs_n_a; rx_at_done = 'x;
        for (int k = 1; k <= 200; k++) begin
            if (busy_a) begin
                busy_cnt++;
                mosi_or = mosi_or | mosi_a;
            end
            if (sclk_a && !prev_sclk) begin
                rises++;
                mosi_word = {mosi_word[6:0], mosi_a};
            end
            if (!sclk_a && prev_sclk) begin
                idx++;
                if (idx < 8) miso_a = pat[7-idx];
            end
            prev_sclk = sclk_a;
            if (done_a) begin
                done_cyc = k;
                rx_at_done = rx_a;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int          dc, bc, rc, ndone, gap, r1, r2;
        logic [7:0]  mw, rxd;
        logic        mo, c1;

        start_a = 0; tx_a = 0; loop_a = 1; miso_a = 0;
        start_b = 0; tx_b = 0;
        rst = 1;
        repeat (3) @(negedge clk);
        check("rst_cs_n", cs_n_a, 1);
        check("rst_sclk", sclk_a, 0);
        check("rst_mosi", mosi_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_rx", rx_a, 0);
        check("rst_busy_b", busy_b, 0);
        rst = 0;
        @(negedge clk);

        // loopback 0xA5
        xfer_a(8'hA5, 0, 8'h00, dc, bc, rc, mw, mo, c1, rxd);
        check("a5_cs_low_next", c1, 0);
        check("a5_done_cyc", dc, 73);
        check("a5_busy_cnt", bc, 73);
        check("a5_rises", rc, 8);
        check("a5_mosi", mw, 8'hA5);
        check("a5_rx_at_done", rxd, 8'hA5);
        check("a5_rx_hold", rx_a, 8'hA5);
        check("a5_idle_busy", busy_a, 0);

        // external miso pattern 0x3C, tx 0x96
        xfer_a(8'h96, 1, 8'h3C, dc, bc, rc, mw, mo, c1, rxd);
        check("pat_rx", rx_a, 8'h3C);
        check("pat_mosi", mw, 8'h96);
        check("pat_done_cyc", dc, 73);

        // tx 0x00, bus changed to 0xFF after acceptance
        xfer_a(8'h00, 0, 8'h00, dc, bc, rc, mw, mo, c1, rxd);
        check("zero_mosi_or", mo, 0);
        check("zero_rx", rx_a, 8'h00);
        check("zero_busy_cnt", bc, 73);

        // starts during busy and in the DONE cycle are dropped
        loop_a = 1; tx_a = 8'h5A; start_a = 1;
        @(negedge clk);
        start_a = 0;
        ndone = 0; bc = 0;
        for (int k = 1; k <= 160; k++) begin
            if (busy_a) bc++;
            if (done_a) ndone++;
            start_a = (k == 10 || k == 40 || k == 73);
            @(negedge clk);
        end
        check("ign_done_cnt", ndone, 1);
        check("ign_busy_cnt", bc, 73);
        check("ign_rx", rx_a, 8'h5A);

        // start held high: back-to-back with one idle cycle between
        tx_a = 8'hC3; start_a = 1;
        @(negedge clk);
        ndone = 0; gap = 0;
        for (int k = 1; k <= 200; k++) begin
            if (done_a) ndone++;
            else if (ndone == 1 && !busy_a) gap++;
            @(negedge clk);
        end
        start_a = 0;
        check("held_done_cnt", ndone, 2);
        check("held_gap", gap, 1);
        check("held_rx", rx_a, 8'hC3);
        for (int k = 0; k < 100 && busy_a; k++) @(negedge clk);
        check("held_drain", busy_a, 0);

        // reset mid-transfer
        tx_a = 8'h0F; start_a = 1;
        @(negedge clk);
        start_a = 0;
        repeat (29) @(negedge clk);
        check("abort_pre_busy", busy_a, 1);
        rst = 1;
        @(negedge clk);
        check("abort_cs_n", cs_n_a, 1);
        check("abort_sclk", sclk_a, 0);
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        check("abort_rx", rx_a, 0);
        rst = 0;
        ndone = 0;
        for (int k = 0; k < 100; k++) begin
            if (done_a || busy_a) ndone++;
            @(negedge clk);
        end
        check("abort_quiet", ndone, 0);
        xfer_a(8'h81, 0, 8'h00, dc, bc, rc, mw, mo, c1, rxd);
        check("after_abort_done", dc, 73);
        check("after_abort_rx", rx_a, 8'h81);

        // CLK_DIV=2, DATA_W=16 loopback
        tx_b = 16'h8001; start_b = 1;
        @(negedge clk);
        start_b = 0; tx_b = 16'h0000;
        bc = 0; rc = 0; dc = -1; r1 = -1; r2 = -1; mo = 0;
        for (int k = 1; k <= 200; k++) begin
            if (busy_b) bc++;
            if (sclk_b && !mo) begin
                rc++;
                if (r1 < 0) r1 = k;
                else if (r2 < 0) r2 = k;
            end
            mo = sclk_b;
            if (done_b && dc < 0) dc = k;
            @(negedge clk);
            if (dc >= 0) break;
        end
        check("b_busy_cnt", bc, 69);
        check("b_done_cyc", dc, 69);
        check("b_rises", rc, 16);
        check("b_period", r2 - r1, 4);
        check("b_rx", rx_b, 16'h8001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 4, SCLK half-period in clk cycles; legal range >=2.
REQ-002 Parameter DATA_W, default 8, bits per transaction; legal range >=2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  transaction request; sampled only when busy=0.
REQ-006 tx_data  input  DATA_W  word to transmit, MSB first; latched on accepted start.
REQ-007 busy  output  1  high from the cycle after an accepted start through the DONE cycle inclusive.
REQ-008 done  output  1  one-cycle pulse at transaction end.
REQ-009 rx_data  output  DATA_W  last received word; holds between transactions.
REQ-010 sclk  output  1  SPI clock, mode 0 (idle low, sample on rising, shift on falling).
REQ-011 mosi  output  1  serial data out.
REQ-012 miso  input  1  serial data in.
REQ-013 cs_n  output  1  active-low chip select.

Function
REQ-014 FSM states SHALL be IDLE, SETUP, XFER, HOLD, DONE.
REQ-015 IDLE: cs_n=1, sclk=0, mosi=0, busy=0; start=1 SHALL latch tx_data into the TX shift register and enter SETUP next cycle.
REQ-016 SETUP: cs_n=0, sclk=0, mosi=TX MSB; SHALL last exactly CLK_DIV cycles, then enter XFER.
REQ-017 XFER: a divider counter (mod CLK_DIV) SHALL toggle sclk on each carry-out, giving SCLK period 2*CLK_DIV clk cycles.
REQ-018 On the clk edge where sclk goes 0->1, miso SHALL be shifted into the RX shift register LSB.
REQ-019 On the clk edge where sclk goes 1->0, the TX register SHALL shift left one bit and a bit counter (mod DATA_W) SHALL increment.
REQ-020 The falling edge on which the bit counter wraps from DATA_W-1 SHALL enter HOLD with sclk=0.
REQ-021 HOLD: cs_n=0, sclk=0; SHALL last exactly CLK_DIV cycles, then enter DONE.
REQ-022 DONE: one cycle; cs_n=1, done=1, rx_data loaded from the RX shift register (visible the cycle done is high); then IDLE.
REQ-023 busy SHALL be high for exactly CLK_DIV*(2*DATA_W+2)+1 cycles per transaction (73 at defaults).
REQ-024 start while busy=1 SHALL be ignored, with no queuing; start in the DONE cycle SHALL be ignored.
REQ-025 start held high continuously SHALL launch back-to-back transactions, each beginning in the first IDLE cycle.
REQ-026 Changes on tx_data after acceptance SHALL NOT affect the transaction in progress.

Reset
REQ-027 rst=1 SHALL force IDLE: cs_n=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0, divider and bit counters cleared.
REQ-028 rst mid-transaction SHALL abort immediately, with no done pulse and rx_data cleared to 0.

Structure
REQ-029 Package spi_pkg SHALL hold the FSM state enum typedef and the CLK_DIV/DATA_W default constants.
REQ-030 Divider and bit counters SHALL be two instances of the team's modulo-M Counter sub-module (clk, rst, en, cnt, co); no other sub-modules.
REQ-031 All outputs SHALL be registered except done and busy, which may decode the state register.

Verification
REQ-032 Defaults, tx_data=0xA5, miso looped to mosi: start pulse -> cs_n low 1 cycle later; 8 sclk rising edges; done at cycle 73; rx_data=0xA5.
REQ-033 miso driven 0x3C MSB-first, changing on falling edges: rx_data=0x3C, mosi reproduces tx_data bit order exactly.
REQ-034 start held high for 200 cycles: exactly 2 complete transactions with 1 IDLE cycle between them; further start pulses during busy are ignored.
REQ-035 rst asserted at cycle 30 of a transfer: next cycle cs_n=1, sclk=0, busy=0, no done pulse, rx_data=0; a new start works normally afterwards.
REQ-036 CLK_DIV=2, DATA_W=16, tx_data=0x8001: SCLK period 4 cycles, busy 69 cycles, 16 rising edges, loopback rx_data=0x8001.
REQ-037 tx_data changed to 0xFF one cycle after start with tx_data=0x00: mosi stays 0 for the whole transfer.
